// File: rtl/fp_adder.sv
// fp_adder: three-stage pipelined IEEE-754 binary16 adder, round-to-nearest-even.
//   CLK     : rising-edge clock
//   RESETn  : asynchronous active-low reset, clears every pipeline register
//   A, B    : binary16 operands, sampled every cycle
//   sum     : registered binary16 result, three cycles after the operands
// Optional feature: define FPADD_SUBNORMAL_EN for gradual underflow; without it
// subnormal inputs are read as signed zero and tiny results flush to signed zero.
module fp_adder (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] sum
);

  localparam int unsigned EW  = 5;        // exponent width
  localparam int unsigned FW  = 10;       // fraction width
  localparam int unsigned SW  = FW + 1;   // significand incl. hidden bit
  localparam int unsigned XW  = SW + 3;   // significand plus guard/round/sticky
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef struct packed {
    logic          special;
    logic [15:0]   special_val;
    logic          sign;
    logic          zero_sign;
    logic          sub;
    logic [EW-1:0] exp;
    logic [EW-1:0] diff;
    logic [SW-1:0] sig_x;
    logic [SW-1:0] sig_y;
  } s1_t;

  typedef struct packed {
    logic          special;
    logic [15:0]   special_val;
    logic          sign;
    logic          zero_sign;
    logic [EW-1:0] exp;
    logic [XW:0]   mag;
  } s2_t;

  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [15:0] sum_d, sum_q;

  // Stage 1: unpack, classify specials, order operands so |X| >= |Y|
  logic [EW-1:0] ea, eb;
  logic [SW-1:0] siga, sigb;
  logic          a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_inf = (A[14:10] == 5'h1F) && (A[9:0] == '0);
    b_inf = (B[14:10] == 5'h1F) && (B[9:0] == '0);
    a_nan = (A[14:10] == 5'h1F) && (A[9:0] != '0);
    b_nan = (B[14:10] == 5'h1F) && (B[9:0] != '0);
`ifdef FPADD_SUBNORMAL_EN
    ea   = (A[14:10] == '0) ? 5'd1 : A[14:10];
    eb   = (B[14:10] == '0) ? 5'd1 : B[14:10];
    siga = {(A[14:10] != '0), A[9:0]};
    sigb = {(B[14:10] != '0), B[9:0]};
`else
    ea   = A[14:10];
    eb   = B[14:10];
    siga = (A[14:10] == '0) ? '0 : {1'b1, A[9:0]};
    sigb = (B[14:10] == '0) ? '0 : {1'b1, B[9:0]};
`endif
  end

  always_comb begin
    s1_d           = '0;
    s1_d.sub       = A[15] ^ B[15];
    s1_d.zero_sign = A[15] & B[15];
    if ({ea, siga} >= {eb, sigb}) begin
      s1_d.sign  = A[15];
      s1_d.exp   = ea;
      s1_d.diff  = ea - eb;
      s1_d.sig_x = siga;
      s1_d.sig_y = sigb;
    end else begin
      s1_d.sign  = B[15];
      s1_d.exp   = eb;
      s1_d.diff  = eb - ea;
      s1_d.sig_x = sigb;
      s1_d.sig_y = siga;
    end
    if (a_nan || b_nan || (a_inf && b_inf && (A[15] != B[15]))) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = QNAN;
    end else if (a_inf) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = A;
    end else if (b_inf) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = B;
    end
  end

  // Stage 2: align Y with sticky collection, then add or subtract
  logic [3:0]    dcap;
  logic [26:0]   y_wide;
  logic [XW-1:0] x_ext, y_ext;

  always_comb begin
    s2_d             = '0;
    s2_d.special     = s1_q.special;
    s2_d.special_val = s1_q.special_val;
    s2_d.sign        = s1_q.sign;
    s2_d.zero_sign   = s1_q.zero_sign;
    s2_d.exp         = s1_q.exp;
    dcap   = (s1_q.diff > 5'd13) ? 4'd13 : s1_q.diff[3:0];
    // Y sits above 16 zero bits so nothing drops off before the sticky OR
    y_wide = {s1_q.sig_y, 16'd0} >> dcap;
    y_ext  = {y_wide[26:14], |y_wide[13:0]};
    x_ext  = {s1_q.sig_x, 3'b000};
    if (s1_q.sub) s2_d.mag = {1'b0, x_ext} - {1'b0, y_ext};
    else          s2_d.mag = {1'b0, x_ext} + {1'b0, y_ext};
  end

  // Stage 3: normalize, (denormalize), round to nearest even, pack
  logic [3:0]        lzc;
  logic [XW-1:0]     norm;
  logic signed [6:0] e;
  logic [EW-1:0]     exp_base;
  logic              underflow;
  logic              inc;
  logic [14:0]       packed_mag;
`ifdef FPADD_SUBNORMAL_EN
  logic [6:0]        sh_full;
  logic [3:0]        shamt;
  logic [27:0]       n_wide;
`endif

  always_comb begin
    lzc = '0;
    for (int i = 0; i < int'(XW); i++) begin
      if (s2_q.mag[i]) lzc = 4'(13 - i);
    end
  end

  always_comb begin
    sum_d     = '0;
    underflow = 1'b0;
    if (s2_q.mag[XW]) begin
      norm = {s2_q.mag[XW:2], s2_q.mag[1] | s2_q.mag[0]};
      e    = $signed({2'b00, s2_q.exp}) + 7'sd1;
    end else begin
      norm = s2_q.mag[XW-1:0] << lzc;
      e    = $signed({2'b00, s2_q.exp}) - $signed({3'b000, lzc});
    end
    // Exponent field is built as (e-1) so the hidden bit carries it up to e
    exp_base = 5'(e - 7'sd1);
`ifdef FPADD_SUBNORMAL_EN
    sh_full = '0;
    shamt   = '0;
    n_wide  = '0;
    if (e < 7'sd1) begin
      sh_full  = 7'(7'sd1 - e);
      shamt    = (sh_full > 7'd14) ? 4'd14 : sh_full[3:0];
      n_wide   = {norm, 14'd0} >> shamt;
      norm     = {n_wide[27:15], |n_wide[14:0]};
      exp_base = '0;
    end
`else
    underflow = (e < 7'sd1);
`endif
    inc        = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Rounding carry ripples into the exponent: renormalization and overflow to Inf come free
    packed_mag = {exp_base, 10'd0} + {4'd0, norm[XW-1:3]} + 15'(inc);
    if (s2_q.special)            sum_d = s2_q.special_val;
    else if (s2_q.mag == '0)     sum_d = {s2_q.zero_sign, 15'd0};
    else if (underflow)          sum_d = {s2_q.sign, 15'd0};
    else if (e >= 7'sd31)        sum_d = {s2_q.sign, 5'h1F, 10'd0};
    else                         sum_d = {s2_q.sign, packed_mag};
  end

  // Pipeline registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_q  <= '0;
      s2_q  <= '0;
      sum_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder: directed self-checking bench for fp_adder (binary16 adder, latency 3).
module tb_fp_adder;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [15:0] A, B;
  logic [15:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int N = 14;

`ifdef FPADD_SUBNORMAL_EN
  localparam logic [15:0] UF_EXP = 16'h8001;
`else
  localparam logic [15:0] UF_EXP = 16'h8000;
`endif

  logic [15:0] va [N] = '{16'h59EC, 16'h570C, 16'h4F30, 16'h5A28, 16'h8000, 16'h4F30, 16'h7BFF,
                          16'h7C00, 16'h7E00, 16'h0400, 16'h7C00, 16'hFC00, 16'h0000, 16'h6800};
  logic [15:0] vb [N] = '{16'h57A6, 16'hD552, 16'h4B14, 16'hDA28, 16'h8000, 16'h0000, 16'h7BFF,
                          16'hFC00, 16'h3C00, 16'h8401, 16'h3C00, 16'hFC00, 16'h8000, 16'h3C00};
  logic [15:0] ve [N];

  fp_adder dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .A      (A),
    .B      (B),
    .sum    (sum)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] expv);
    n_cmp++;
    assert (sum === expv) else begin
      n_bad++;
      $error("FAIL %s: sum=%h expected=%h", tag, sum, expv);
    end
  endtask

  initial begin
    ve = '{16'h5CE0, 16'h4EE8, 16'h515D, 16'h0000, 16'h8000, 16'h4F30, 16'h7C00,
           16'h7E00, 16'h7E00, UF_EXP, 16'h7C00, 16'hFC00, 16'h0000, 16'h6800};

    // Reset held for 50 time units with live operands
    RESETn = 1'b0;
    A = 16'h59EC;
    B = 16'h57A6;
    #1;
    check("reset_t0", 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("reset_hold", 16'h0000);
    end

    // Release and confirm the exact 3-edge latency
    RESETn = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("latency_edge2", 16'h0000);
    @(posedge CLK);
    @(negedge CLK);
    check("first_result", 16'h5CE0);

    // Back-to-back stream: each result three cycles after its operands
    for (int i = 0; i < N + 3; i++) begin
      @(negedge CLK);
      if (i >= 3) check($sformatf("stream_%0d_%h_%h", i - 3, va[i-3], vb[i-3]), ve[i-3]);
      if (i < N) begin
        A = va[i];
        B = vb[i];
      end else begin
        A = 16'h3C00;
        B = 16'h3C00;
      end
    end
    @(negedge CLK);
    check("one_plus_one", 16'h4000);

    // Mid-operation reset clears sum immediately and drops in-flight results
    A = 16'h570C;
    B = 16'hD552;
    repeat (4) @(negedge CLK);
    check("pre_midreset", 16'h4EE8);
    #1;
    RESETn = 1'b0;
    #1;
    check("midreset_async", 16'h0000);
    A = 16'h4F30;
    B = 16'h4B14;
    @(negedge CLK);
    check("midreset_hold", 16'h0000);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    check("midreset_flushed", 16'h0000);
    @(negedge CLK);
    check("after_midreset", 16'h515D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
